// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator arithmetic core.
// Number format: bit WIDTH-1 is the sign (1 = negative), bits MAG_W-1:0 the magnitude.
// Contents: word/magnitude widths, multiplier iteration count, multiplier state
// enum and sign-magnitude pack/unpack helpers.
package calc_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned MAG_W      = WIDTH - 1;
    localparam int unsigned MUL_CYCLES = MAG_W;
    localparam int unsigned MUL_CNT_W  = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        MulIdle,
        MulBusy,
        MulDone
    } mul_state_e;

    function automatic logic sm_sign(input logic [WIDTH-1:0] v);
        return v[WIDTH-1];
    endfunction

    function automatic logic [MAG_W-1:0] sm_mag(input logic [WIDTH-1:0] v);
        return v[MAG_W-1:0];
    endfunction

    // Builds a word and forces the sign to 0 on a zero magnitude, so -0 never leaves the core.
    function automatic logic [WIDTH-1:0] sm_pack(input logic s, input logic [MAG_W-1:0] m);
        return {s & (|m), m};
    endfunction

endpackage

// File: rtl/sm_multiplier.sv
// Iterative sign-magnitude multiplier, one multiplier bit per cycle.
// Ports:
//   clk, nRST     - clock, asynchronous active-low reset
//   in1, in2      - sign-magnitude operands, latched when start is accepted in IDLE
//   start         - launch request, ignored unless IDLE
//   product       - registered result, holds until the next completed multiply
//   finish        - one-cycle pulse in the DONE state
// Product magnitude is (m1 * m2) mod 2^MAG_W; overflow wraps without a flag.
module sm_multiplier
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             nRST,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             start,
    output logic [WIDTH-1:0] product,
    output logic             finish
);

    localparam logic [MUL_CNT_W-1:0] LastIter = MUL_CNT_W'(MUL_CYCLES - 1);

    mul_state_e           state_q, state_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [MAG_W-1:0]     mcand_q, mcand_d;
    logic [MAG_W-1:0]     mplier_q, mplier_d;
    logic [MAG_W-1:0]     acc_q, acc_d;
    logic                 sign_q, sign_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [MAG_W-1:0]     acc_step;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        out_d    = out_q;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            MulIdle: begin
                if (start) begin
                    state_d  = MulBusy;
                    cnt_d    = '0;
                    mcand_d  = sm_mag(in1);
                    mplier_d = sm_mag(in2);
                    acc_d    = '0;
                    sign_d   = sm_sign(in1) ^ sm_sign(in2);
                end
            end
            MulBusy: begin
                // Bits shifted past the top of mcand only affect product bits >= MAG_W.
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = MulDone;
                    out_d   = sm_pack(sign_q, acc_step);
                end
            end
            MulDone: begin
                state_d = MulIdle;
            end
            default: begin
                state_d = MulIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q  <= MulIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            out_q    <= out_d;
        end
    end

    assign product = out_q;
    assign finish  = (state_q == MulDone);

endmodule

// File: rtl/signed_arith_unit.sv
// Sign-magnitude arithmetic core for the keypad calculator.
// Ports:
//   clk, nRST                       - clock, asynchronous active-low reset
//   add_in1, add_in2, add_sub       - adder operands; add_sub = 1 computes in1 - in2
//   add_start / add_out / add_finish - one-cycle add/sub, result and pulse the next cycle
//   mul_in1, mul_in2                - multiplier operands
//   mul_start / mul_out / mul_finish - iterative multiply, result and pulse 16 cycles later
// The two units are fully independent and may run concurrently.
module signed_arith_unit
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             nRST,
    input  logic [WIDTH-1:0] add_in1,
    input  logic [WIDTH-1:0] add_in2,
    input  logic             add_sub,
    input  logic             add_start,
    output logic [WIDTH-1:0] add_out,
    output logic             add_finish,
    input  logic [WIDTH-1:0] mul_in1,
    input  logic [WIDTH-1:0] mul_in2,
    input  logic             mul_start,
    output logic [WIDTH-1:0] mul_out,
    output logic             mul_finish
);

    logic             s1, s2;
    logic [MAG_W-1:0] m1, m2;
    logic             sum_sign;
    logic [MAG_W-1:0] sum_mag;
    logic [WIDTH-1:0] add_out_q;
    logic             add_finish_q;

    // Subtraction is addition with the second sign flipped. A -0 input needs no special
    // handling: it either lands in the magnitude-compare path or yields a zero that
    // sm_pack normalises.
    always_comb begin
        s1 = sm_sign(add_in1);
        m1 = sm_mag(add_in1);
        s2 = sm_sign(add_in2) ^ add_sub;
        m2 = sm_mag(add_in2);
        if (s1 == s2) begin
            sum_mag  = m1 + m2;
            sum_sign = s1;
        end else if (m1 >= m2) begin
            sum_mag  = m1 - m2;
            sum_sign = s1;
        end else begin
            sum_mag  = m2 - m1;
            sum_sign = s2;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            add_out_q    <= '0;
            add_finish_q <= 1'b0;
        end else begin
            add_finish_q <= add_start;
            if (add_start) begin
                add_out_q <= sm_pack(sum_sign, sum_mag);
            end
        end
    end

    assign add_out    = add_out_q;
    assign add_finish = add_finish_q;

    sm_multiplier u_mul (
        .clk     (clk),
        .nRST    (nRST),
        .in1     (mul_in1),
        .in2     (mul_in2),
        .start   (mul_start),
        .product (mul_out),
        .finish  (mul_finish)
    );

endmodule

// File: tb/tb_signed_arith_unit.sv
// Directed bench for signed_arith_unit with hand-computed expected values.
module tb_signed_arith_unit;

    logic        clk;
    logic        nRST;
    logic [15:0] add_in1, add_in2;
    logic        add_sub, add_start;
    logic [15:0] add_out;
    logic        add_finish;
    logic [15:0] mul_in1, mul_in2;
    logic        mul_start;
    logic [15:0] mul_out;
    logic        mul_finish;

    int checks = 0;
    int errors = 0;

    signed_arith_unit dut (
        .clk        (clk),
        .nRST       (nRST),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .add_sub    (add_sub),
        .add_start  (add_start),
        .add_out    (add_out),
        .add_finish (add_finish),
        .mul_in1    (mul_in1),
        .mul_in2    (mul_in2),
        .mul_start  (mul_start),
        .mul_out    (mul_out),
        .mul_finish (mul_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic [15:0] exp, input string tag);
        add_in1   = a;
        add_in2   = b;
        add_sub   = sub;
        add_start = 1'b1;
        check({tag, " finish in start cycle"}, {15'b0, add_finish}, 16'h0000);
        step();
        add_start = 1'b0;
        check({tag, " finish at +1"}, {15'b0, add_finish}, 16'h0001);
        check({tag, " result"}, add_out, exp);
        step();
        check({tag, " finish at +2"}, {15'b0, add_finish}, 16'h0000);
        check({tag, " result hold"}, add_out, exp);
    endtask

    // Called just after the edge that sampled mul_start (cycle k+1).
    task automatic mul_track(input logic [15:0] exp, input string tag);
        check({tag, " finish at +1"}, {15'b0, mul_finish}, 16'h0000);
        for (int i = 2; i <= 15; i++) begin
            step();
            check({tag, " finish early"}, {15'b0, mul_finish}, 16'h0000);
        end
        step();
        check({tag, " finish at +16"}, {15'b0, mul_finish}, 16'h0001);
        check({tag, " product"}, mul_out, exp);
    endtask

    task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input string tag);
        mul_in1   = a;
        mul_in2   = b;
        mul_start = 1'b1;
        check({tag, " finish in start cycle"}, {15'b0, mul_finish}, 16'h0000);
        step();
        mul_start = 1'b0;
        mul_track(exp, tag);
        step();
        check({tag, " finish at +17"}, {15'b0, mul_finish}, 16'h0000);
        check({tag, " product hold"}, mul_out, exp);
    endtask

    logic [15:0] chain_prod[3] = '{16'h0000, 16'h000A, 16'h0078};
    logic [15:0] chain_sum[3]  = '{16'h0001, 16'h000C, 16'h007B};
    logic [15:0] chain_val;

    initial begin
        nRST      = 1'b0;
        add_in1   = '0;
        add_in2   = '0;
        add_sub   = 1'b0;
        add_start = 1'b0;
        mul_in1   = '0;
        mul_in2   = '0;
        mul_start = 1'b0;

        // Reset state
        #12;
        check("reset add_out", add_out, 16'h0000);
        check("reset mul_out", mul_out, 16'h0000);
        check("reset add_finish", {15'b0, add_finish}, 16'h0000);
        check("reset mul_finish", {15'b0, mul_finish}, 16'h0000);
        @(negedge clk);
        nRST = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle add_finish", {15'b0, add_finish}, 16'h0000);
            check("idle mul_finish", {15'b0, mul_finish}, 16'h0000);
        end

        // Add/sub
        do_add(16'h0005, 16'h0003, 1'b0, 16'h0008, "add 5+3");
        do_add(16'h0003, 16'h0005, 1'b1, 16'h8002, "sub 3-5");
        do_add(16'h8005, 16'h0005, 1'b0, 16'h0000, "add -5+5");
        do_add(16'h7FFF, 16'h0001, 1'b0, 16'h0000, "add wrap");
        do_add(16'h8000, 16'h0004, 1'b1, 16'h8004, "sub -0-4");

        // Multiply
        do_mul(16'h0007, 16'h000A, 16'h0046, "mul 7x10");
        do_mul(16'h8003, 16'h000A, 16'h801E, "mul -3x10");
        do_mul(16'h8003, 16'h8002, 16'h0006, "mul -3x-2");
        do_mul(16'h4000, 16'h0002, 16'h0000, "mul wrap");

        // Digit-entry chain: value = value*10 + digit
        chain_val = 16'h0000;
        for (int d = 0; d < 3; d++) begin
            do_mul(chain_val, 16'h000A, chain_prod[d], "chain mul");
            do_add(chain_prod[d], 16'(d + 1), 1'b0, chain_sum[d], "chain add");
            chain_val = chain_sum[d];
        end

        // Concurrent add and multiply started in the same cycle
        mul_in1   = 16'h0007;
        mul_in2   = 16'h0003;
        add_in1   = 16'h0010;
        add_in2   = 16'h8004;
        add_sub   = 1'b0;
        mul_start = 1'b1;
        add_start = 1'b1;
        step();
        mul_start = 1'b0;
        add_start = 1'b0;
        check("conc add_finish +1", {15'b0, add_finish}, 16'h0001);
        check("conc add_out", add_out, 16'h000C);
        mul_track(16'h0015, "conc mul");
        check("conc add_out hold", add_out, 16'h000C);
        step();
        check("conc mul_finish +17", {15'b0, mul_finish}, 16'h0000);

        // Restart while BUSY is ignored; start in DONE ignored, next cycle accepted
        mul_in1   = 16'h0005;
        mul_in2   = 16'h0006;
        mul_start = 1'b1;
        step();
        mul_start = 1'b0;
        check("busy finish +1", {15'b0, mul_finish}, 16'h0000);
        for (int j = 2; j <= 15; j++) begin
            if (j == 5) begin
                mul_start = 1'b1;
                mul_in1   = 16'h0002;
                mul_in2   = 16'h0002;
            end
            step();
            mul_start = 1'b0;
            check("busy finish early", {15'b0, mul_finish}, 16'h0000);
        end
        step();
        check("busy finish +16", {15'b0, mul_finish}, 16'h0001);
        check("busy product", mul_out, 16'h001E);
        mul_in1   = 16'h0003;
        mul_in2   = 16'h0003;
        mul_start = 1'b1;
        step();
        check("done-cycle start ignored", {15'b0, mul_finish}, 16'h0000);
        step();
        mul_start = 1'b0;
        mul_track(16'h0009, "restart mul");

        // Reset in the middle of a multiply
        mul_in1   = 16'h0007;
        mul_in2   = 16'h0007;
        mul_start = 1'b1;
        step();
        mul_start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        nRST = 1'b0;
        #1;
        check("abort mul_out", mul_out, 16'h0000);
        check("abort add_out", add_out, 16'h0000);
        check("abort mul_finish", {15'b0, mul_finish}, 16'h0000);
        @(negedge clk);
        nRST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("abort no finish", {15'b0, mul_finish}, 16'h0000);
        end
        check("abort mul_out held", mul_out, 16'h0000);
        do_mul(16'h0002, 16'h0009, 16'h0012, "post-abort mul");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
